// File: rtl/raggedstone_spinn_aer_if_status_tx_if.sv
// Outbound 72-bit SpiNNaker packet channel with valid/ready flow control.
interface raggedstone_spinn_aer_if_status_tx_if;
  logic [71:0] spkt_data;
  logic        spkt_vld;
  logic        spkt_rdy;

  modport master (output spkt_data, output spkt_vld, input spkt_rdy);
  modport slave  (input spkt_data, input spkt_vld, output spkt_rdy);
endinterface

// File: rtl/raggedstone_spinn_aer_if_status_tx.sv
// Status packet transmitter: reports go changes, explicit requests and a periodic
// heartbeat as multicast packets keyed on STATUS_KEY with go in key bit 0.
module raggedstone_spinn_aer_if_status_tx #(
  parameter logic [31:0] STATUS_KEY = 32'hFEFF_FE00,
  parameter logic [23:0] HB_PERIOD  = 24'd10_000_000,
  parameter logic        INIT_GO    = 1'b0,
  parameter int          MODE_W     = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  go,
  input  logic [MODE_W-1:0]                     vmode,
  input  logic                                  status_req,
  raggedstone_spinn_aer_if_status_tx_if.master  spkt,
  output logic                                  busy
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t       state, state_n;
  logic         go_q;
  logic         pend_chg, pend_req, pend_hb;
  logic         chg_n, req_n, hb_n;
  logic         clr_chg, clr_req, clr_hb;
  logic [23:0]  hb_cnt, hb_cnt_n;
  logic         hb_evt;
  logic [7:0]   seq, seq_n;
  logic [71:0]  data_q, data_n;
  logic         vld_q, vld_n;
  logic [1:0]   code;
  logic [7:0]   vm8;
  logic [70:0]  body;
  logic [71:0]  pkt;

  // Heartbeat counter; a zero period parks it at 0 forever.
  always_comb begin
    hb_cnt_n = '0;
    hb_evt   = 1'b0;
    if (HB_PERIOD != 24'd0) begin
      if (hb_cnt == HB_PERIOD - 24'd1) hb_evt = 1'b1;
      else                              hb_cnt_n = hb_cnt + 24'd1;
    end
  end

  // Packet image built from the highest-priority pending event.
  always_comb begin
    code = pend_chg ? 2'b01 : (pend_req ? 2'b10 : 2'b11);
    vm8  = 8'(vmode);
    body = {seq, 14'b0, code, vm8, STATUS_KEY[31:1], go_q, 6'b0, 1'b1};
    pkt  = {body, ~^body};
  end

  always_comb begin
    state_n = state;
    data_n  = data_q;
    vld_n   = vld_q;
    seq_n   = seq;
    clr_chg = 1'b0;
    clr_req = 1'b0;
    clr_hb  = 1'b0;
    case (state)
      IDLE: begin
        if (pend_chg | pend_req | pend_hb) begin
          data_n  = pkt;
          vld_n   = 1'b1;
          state_n = SEND;
          clr_chg = pend_chg;
          clr_req = ~pend_chg & pend_req;
          clr_hb  = ~pend_chg & ~pend_req & pend_hb;
        end
      end
      SEND: begin
        if (vld_q && spkt.spkt_rdy) begin
          vld_n   = 1'b0;
          seq_n   = seq + 8'd1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // A new event on the same edge as service keeps the flag set.
  always_comb begin
    chg_n = (pend_chg & ~clr_chg) | (go != go_q);
    req_n = (pend_req & ~clr_req) | status_req;
    hb_n  = (pend_hb  & ~clr_hb)  | hb_evt;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      go_q     <= INIT_GO;
      pend_chg <= 1'b0;
      pend_req <= 1'b0;
      pend_hb  <= 1'b0;
      hb_cnt   <= '0;
      seq      <= '0;
      data_q   <= '0;
      vld_q    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      go_q     <= go;
      pend_chg <= chg_n;
      pend_req <= req_n;
      pend_hb  <= hb_n;
      hb_cnt   <= hb_cnt_n;
      seq      <= seq_n;
      data_q   <= data_n;
      vld_q    <= vld_n;
      busy     <= (state_n == SEND) | chg_n | req_n | hb_n;
    end
  end

  assign spkt.spkt_data = data_q;
  assign spkt.spkt_vld  = vld_q;

endmodule

// File: doc/raggedstone_spinn_aer_if_status_tx.md
Name: raggedstone_spinn_aer_if_status_tx

Overview:
- Transmit side of the interface's control path. The control block receives command packets that set `go`; this block sends status packets back toward SpiNNaker.
- Emits a multicast packet when `go` changes, on an explicit status request, and on a periodic heartbeat.
- Output uses a valid/ready packet interface that feeds the SpiNNaker-link transmitter.
- Sits between the control block outputs (go, vmode) and the outbound packet arbiter.

Parameters:
- STATUS_KEY, 32'hFEFF_FE00, base routing key; bit 0 is replaced by the current go value.
- HB_PERIOD, 24'd10_000_000, heartbeat interval in clk cycles; 0 disables the heartbeat.
- INIT_GO, 1'b0, reset value of the internal go history (matches control-block reset go).
- MODE_W, 2, width of vmode; must be ≤ 8.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- go  in  1  current go state from control block
- vmode  in  MODE_W  current interface mode
- status_req  in  1  single-cycle request for a status packet
- spkt_data  out  72  outbound packet
- spkt_vld  out  1  packet valid
- spkt_rdy  in  1  downstream ready
- busy  out  1  high while any event is pending or a packet is in flight

Behaviour:
- Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - spkt_vld=0, spkt_data=0, busy=0
  - seq=0, heartbeat counter=0
  - all pending flags=0
  - go_q=INIT_GO
  - state=IDLE
- Event detection, registered on every edge:
  - go_q<=go.
  - If go!=go_q, set pend_chg.
  - If status_req=1, set pend_req.
  - If HB_PERIOD!=0: the counter increments each cycle. When it equals HB_PERIOD-1 it wraps to 0 and sets pend_hb.
  - If HB_PERIOD=0: the counter is held at 0 and pend_hb is never set.
- State machine, 2 states:
  - IDLE: if any pend_* is set, load spkt_data, set spkt_vld=1, clear only the served flag, go to SEND. Served flag priority is pend_chg > pend_req > pend_hb.
  - SEND: spkt_data and spkt_vld are held stable while spkt_rdy=0. On an edge with spkt_vld=1 and spkt_rdy=1: spkt_vld<=0, seq<=seq+1 (8-bit, wraps 255->0), go to IDLE.
- Throughput: at most one packet per 2 cycles.
- Latency: go changes before edge E0 -> pend_chg set at E0 -> spkt_vld=1 after E1.
- Coalescing:
  - Repeated events of one type while its flag is already set merge into one packet.
  - If an event arrives on the same edge its flag is cleared by service, set wins and the flag stays 1.
  - go toggling twice while blocked produces one pending change. The packet reports the go value sampled at load time.
- Packet format, loaded in IDLE:
  - [7:6]=2'b00 (multicast)
  - [1]=1 (payload present)
  - [5:2]=0
  - [39:8]=key: {STATUS_KEY[31:1], go_q}
  - [71:40]=payload: {seq[7:0], 14'b0, code[1:0], 8-bit zero-extended vmode}
  - code: 01=go change, 10=request, 11=heartbeat
  - [0]=parity, chosen so that the count of ones over [71:0] is odd.
- busy = (state==SEND) | pend_chg | pend_req | pend_hb, registered.
- Reset while in SEND: the packet is dropped, spkt_vld=0 on the next cycle, seq restarts at 0.
- Nothing is transmitted at reset release unless go differs from INIT_GO.

Test Plan:
- go 0->1 with spkt_rdy held 1, HB_PERIOD=0 -> spkt_vld rises after the 2nd edge; key=0xFEFFFE01; payload=0x00000100; parity makes the packet's ones count odd; vld is high for 1 cycle.
- spkt_rdy=0 for 20 cycles after vld, with status_req pulsed 3 times during the stall -> spkt_data is stable; after rdy, exactly one request packet follows (code 10, seq=1).
- status_req and a go change on the same cycle -> the change packet is sent first (code 01, seq=0), then the request packet (code 10, seq=1).
- HB_PERIOD=16, idle inputs, rdy=1 -> a heartbeat packet every 16 cycles with code 11; seq increments; after 256 packets seq wraps to 0.
- Reset asserted during SEND with rdy=0 -> on the next cycle vld=0, busy=0, and a later packet carries seq=0.
- go pulsed 0->1->0 while blocked -> one change packet reporting go=0 (key bit 0 = 0).
